// File: rtl/func_unit_pkg.sv
// func_unit_pkg: shared data width and function-select opcodes for the function unit
package func_unit_pkg;
    localparam int WIDTH = 32;
    localparam logic [3:0] FS_MOVA  = 4'b0000;
    localparam logic [3:0] FS_INC   = 4'b0001;
    localparam logic [3:0] FS_ADD   = 4'b0010;
    localparam logic [3:0] FS_ADDC  = 4'b0011;
    localparam logic [3:0] FS_ADDNB = 4'b0100;
    localparam logic [3:0] FS_SUB   = 4'b0101;
    localparam logic [3:0] FS_DEC   = 4'b0110;
    localparam logic [3:0] FS_MOVA1 = 4'b0111;
    localparam logic [3:0] FS_AND   = 4'b1000;
    localparam logic [3:0] FS_OR    = 4'b1001;
    localparam logic [3:0] FS_XOR   = 4'b1010;
    localparam logic [3:0] FS_NOTA  = 4'b1011;
    localparam logic [3:0] FS_MOVB  = 4'b1100;
    localparam logic [3:0] FS_SRL   = 4'b1101;
    localparam logic [3:0] FS_SLL   = 4'b1110;
    localparam logic [3:0] FS_RSVD  = 4'b1111;
endpackage

// File: rtl/func_unit_core_if.sv
// func_unit_core_if: operand/select inputs and registered result/flag outputs of the function unit
// master drives FS, SH, A, B and observes F, V, C, N, Z; slave is the function unit side
interface func_unit_core_if #(parameter int WIDTH = 32);
    logic [3:0]               FS;
    logic [$clog2(WIDTH)-1:0] SH;
    logic [WIDTH-1:0]         A;
    logic [WIDTH-1:0]         B;
    logic [WIDTH-1:0]         F;
    logic                     V;
    logic                     C;
    logic                     N;
    logic                     Z;
    modport master (output FS, SH, A, B, input F, V, C, N, Z);
    modport slave  (input FS, SH, A, B, output F, V, C, N, Z);
endinterface

// File: rtl/func_shifter.sv
// func_shifter: logarithmic barrel shifter, zero fill
// ports: b (data in), sh (amount), left (1 = shift left, 0 = logical right), y (result)
module func_shifter #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] sh,
    input  logic                     left,
    output logic [WIDTH-1:0]         y
);
    localparam int L = $clog2(WIDTH);
    logic [WIDTH-1:0] s [0:L];
    assign s[0] = b;
    // stage k shifts by 2**k when bit k of the amount is set
    for (genvar k = 0; k < L; k++) begin : g_stage
        assign s[k+1] = sh[k] ? (left ? s[k] << (1 << k) : s[k] >> (1 << k)) : s[k];
    end
    assign y = s[L];
endmodule

// File: rtl/func_unit_core.sv
// func_unit_core: registered 32-bit ALU plus barrel shifter with V/C/N/Z flags
// ports: clk, rst_n (async active-low), bus (slave: FS, SH, A, B in; F, V, C, N, Z registered out)
module func_unit_core #(parameter int WIDTH = 32) (
    input  logic            clk,
    input  logic            rst_n,
    func_unit_core_if.slave bus
);
    import func_unit_pkg::*;
    logic [WIDTH-1:0] y, shifted, lu, f_nxt;
    logic [WIDTH:0]   sum;
    logic             c_nxt, v_nxt;
    func_shifter #(.WIDTH(WIDTH)) u_shifter (
        .b    (bus.B),
        .sh   (bus.SH),
        .left (bus.FS == FS_SLL),
        .y    (shifted)
    );
    always_comb begin
        y = bus.FS[2:1] == 2'b00 ? '0 :
            bus.FS[2:1] == 2'b01 ? bus.B :
            bus.FS[2:1] == 2'b10 ? ~bus.B : '1;
        // one adder covers the whole arithmetic group; bit WIDTH is the carry out
        sum = {1'b0, bus.A} + {1'b0, y} + (WIDTH+1)'(bus.FS[0]);
        lu = bus.FS == FS_AND  ? bus.A & bus.B :
             bus.FS == FS_OR   ? bus.A | bus.B :
             bus.FS == FS_XOR  ? bus.A ^ bus.B :
             bus.FS == FS_NOTA ? ~bus.A :
             bus.FS == FS_MOVB ? bus.B :
             (bus.FS == FS_SRL || bus.FS == FS_SLL) ? shifted : '0;
        f_nxt = bus.FS[3] ? lu : sum[WIDTH-1:0];
        c_nxt = ~bus.FS[3] & sum[WIDTH];
        v_nxt = ~bus.FS[3] & (bus.A[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != bus.A[WIDTH-1]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.F <= '0;
            bus.V <= 1'b0;
            bus.C <= 1'b0;
            bus.N <= 1'b0;
            bus.Z <= 1'b0;
        end else begin
            bus.F <= f_nxt;
            bus.V <= v_nxt;
            bus.C <= c_nxt;
            bus.N <= f_nxt[WIDTH-1];
            bus.Z <= f_nxt == '0;
        end
    end
endmodule

// File: tb/tb_func_unit_core.sv
// tb_func_unit_core: directed and random scoreboard bench for func_unit_core
module tb_func_unit_core;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int errors = 0;
    int checks = 0;
    typedef struct {
        string       tag;
        logic [31:0] f;
        logic [3:0]  vcnz;
    } exp_t;
    exp_t q[$];
    func_unit_core_if #(.WIDTH(32)) u ();
    func_unit_core #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(u));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // reference: each opcode written from its arithmetic meaning
    function automatic exp_t model(input string tag, input logic [3:0] fs, input logic [4:0] sh,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] s;
        logic [31:0] yo;
        logic v, c;
        v = 1'b0;
        c = 1'b0;
        yo = 32'h0;
        s = 33'h0;
        case (fs)
            4'b0000: begin s = {1'b0, a}; end
            4'b0001: begin s = {a == 32'hFFFF_FFFF, a + 32'd1}; end
            4'b0010: begin s = {1'b0, a} + {1'b0, b}; yo = b; end
            4'b0011: begin s = {1'b0, a} + {1'b0, b} + 33'd1; yo = b; end
            4'b0100: begin s = {1'b0, a} + {1'b0, ~b}; yo = ~b; end
            4'b0101: begin s = {a >= b, a - b}; yo = ~b; end
            4'b0110: begin s = {a != 32'h0, a - 32'd1}; yo = 32'hFFFF_FFFF; end
            4'b0111: begin s = {1'b1, a}; yo = 32'hFFFF_FFFF; end
            4'b1000: s = {1'b0, a & b};
            4'b1001: s = {1'b0, a | b};
            4'b1010: s = {1'b0, a ^ b};
            4'b1011: s = {1'b0, ~a};
            4'b1100: s = {1'b0, b};
            4'b1101: s = {1'b0, b >> sh};
            4'b1110: s = {1'b0, b << sh};
            default: s = 33'h0;
        endcase
        if (!fs[3]) begin
            c = s[32];
            v = (a[31] == yo[31]) && (s[31] != a[31]);
        end
        e.tag = tag;
        e.f = s[31:0];
        e.vcnz = {v, c, s[31], s[31:0] == 32'h0};
        return e;
    endfunction
    // issue one op before the next edge, then compare right after that edge
    task automatic op(input string tag, input logic [3:0] fs, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        u.FS = fs;
        u.SH = sh;
        u.A = a;
        u.B = b;
        q.push_back(model(tag, fs, sh, a, b));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_empty"}, 32'h1, 32'h0);
        end else begin
            e = q.pop_front();
            chk({e.tag, "_F"}, u.F, e.f);
            chk({e.tag, "_VCNZ"}, {28'h0, u.V, u.C, u.N, u.Z}, {28'h0, e.vcnz});
        end
    endtask
    initial begin
        u.FS = 4'h0;
        u.SH = 5'h0;
        u.A = 32'h0;
        u.B = 32'h0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_F", u.F, 32'h0);
        chk("rst_flags", {28'h0, u.V, u.C, u.N, u.Z}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold", u.F, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op("inc_wrap", 4'b0001, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678);
        chk("inc_wrap_const", {28'h0, u.V, u.C, u.N, u.Z}, 32'h5);
        op("addc_zero", 4'b0011, 5'd7, 32'h0, 32'hFFFF_FFFF);
        op("add_ovf", 4'b0010, 5'd0, 32'h7FFF_FFFF, 32'h1);
        chk("add_ovf_const", u.F, 32'h8000_0000);
        op("addnb", 4'b0100, 5'd0, 32'h7FFF_FFFF, 32'h1);
        op("sub", 4'b0101, 5'd0, 32'h7FFF_FFFF, 32'h1);
        chk("sub_const", u.F, 32'h7FFF_FFFE);
        op("dec_one", 4'b0110, 5'd3, 32'h1, 32'hDEAD_BEEF);
        op("dec_zero", 4'b0110, 5'd0, 32'h0, 32'h0);
        chk("dec_zero_const", u.F, 32'hFFFF_FFFF);
        op("mova", 4'b0000, 5'd9, 32'd10, 32'hFFFF_FFFF);
        op("mova1", 4'b0111, 5'd0, 32'd10, 32'h5555_5555);
        chk("mova1_C", {31'h0, u.C}, 32'h1);
        op("sub_neg_ovf", 4'b0101, 5'd0, 32'h8000_0000, 32'h1);
        op("and", 4'b1000, 5'd0, 32'h0FFF_FFFF, 32'hFFFF_FFFF);
        op("or", 4'b1001, 5'd0, 32'hF000_0000, 32'h0FFF_FFFF);
        op("xor", 4'b1010, 5'd0, 32'h0000_FFFF, 32'h0FFF_FFFF);
        chk("xor_const", u.F, 32'h0FFF_0000);
        op("nota", 4'b1011, 5'd12, 32'h1, 32'hABCD_0123);
        op("movb", 4'b1100, 5'd0, 32'h9999_9999, 32'h1);
        op("sll31", 4'b1110, 5'd31, 32'h0, 32'h1);
        chk("sll31_const", u.F, 32'h8000_0000);
        op("sll6", 4'b1110, 5'd6, 32'hFFFF_FFFF, 32'h1);
        op("srl31", 4'b1101, 5'd31, 32'h0, 32'h8000_0000);
        chk("srl31_const", u.F, 32'h1);
        op("srl4", 4'b1101, 5'd4, 32'h0, 32'h8000_0000);
        op("srl0", 4'b1101, 5'd0, 32'h0, 32'hA5A5_0F0F);
        op("sll0", 4'b1110, 5'd0, 32'h0, 32'hA5A5_0F0F);
        op("rsvd", 4'b1111, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 40; i++)
            op($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               $urandom, $urandom);
        op("pre_rst", 4'b1100, 5'd0, 32'h0, 32'hCAFE_F00D);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_F", u.F, 32'h0);
        chk("midrst_flags", {28'h0, u.V, u.C, u.N, u.Z}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op("post_rst", 4'b0010, 5'd0, 32'd3, 32'd4);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
